// File: rtl/tpsram_pkg.sv
// Shared types and helpers for the parametrised two-port SRAM controller.
// Provides the state encoding, the byte width and a constant-safe clog2.
package tpsram_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tpsram_core_mem.sv
// DEPTH x DATA_WIDTH storage array with a byte-enable write port and a
// registered read port that returns the word as it was before a same-edge write.
module tpsram_core_mem
    import tpsram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 64
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [ADDR_WIDTH-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic [DATA_WIDTH/8-1:0]    wbe,
    input  logic                       re,
    input  logic [ADDR_WIDTH-1:0]      raddr,
    output logic [DATA_WIDTH-1:0]      rdata
);

    localparam int NB = DATA_WIDTH / BYTE_W;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    // NOTE: the array has no reset; clearing is done by the controller's sweep
    // so the storage can map onto plain SRAM macros. Non-blocking writes keep a
    // same-edge read returning the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    mem[waddr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
                end
            end
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/tpsram_pipe_ctrl.sv
// Two-port SRAM controller: post-reset clear sweep, byte-enable writes,
// write-to-read forwarding, optional output pipeline stage and valid tracking.
module tpsram_pipe_ctrl
    import tpsram_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 6,
    parameter int DEPTH          = 64,
    parameter int RD_PIPE        = 0,
    parameter int FWD_EN         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    CLK,
    input  logic                    SRST,
    input  logic                    WEN,
    input  logic [ADDR_WIDTH-1:0]   WADDR,
    input  logic [DATA_WIDTH-1:0]   WD,
    input  logic [DATA_WIDTH/8-1:0] WBE,
    input  logic                    REN,
    input  logic [ADDR_WIDTH-1:0]   RADDR,
    output logic [DATA_WIDTH-1:0]   RD,
    output logic                    RD_VALID,
    output logic                    BUSY
);

    localparam int NB    = DATA_WIDTH / BYTE_W;
    localparam int CNT_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_A  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEPTH - 1);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    wr_ok, rd_ok, wr_in_range, rd_in_range;
    logic                    mem_we, mem_re;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata, mem_rdata;
    logic [NB-1:0]           mem_wbe;
    logic                    vld0_q, vld0_d, zero0_q, zero0_d;
    logic [NB-1:0]           fwd_be_q, fwd_be_d;
    logic [DATA_WIDTH-1:0]   fwd_wd_q, fwd_wd_d;
    logic [DATA_WIDTH-1:0]   rd0;
    logic [DATA_WIDTH-1:0]   rd1_q, rd1_d;
    logic                    vld1_q, vld1_d;

    always_comb begin
        wr_in_range = {1'b0, WADDR} < DEPTH_A;
        rd_in_range = {1'b0, RADDR} < DEPTH_A;
        wr_ok       = !SRST && (state_q == ST_RUN) && WEN && wr_in_range;
        rd_ok       = !SRST && (state_q == ST_RUN) && REN;
        mem_re      = rd_ok && rd_in_range;
    end

    // Write port is owned by the sweep while clearing, by the user otherwise.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = wr_ok;
        mem_waddr = WADDR;
        mem_wdata = WD;
        mem_wbe   = WBE;
        if (!SRST && (state_q == ST_CLEAR)) begin
            mem_we    = 1'b1;
            mem_waddr = ADDR_WIDTH'(cnt_q);
            mem_wdata = '0;
            mem_wbe   = '1;
            cnt_d     = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        end
    end

    // Side information for the word arriving from the core next cycle.
    always_comb begin
        vld0_d   = rd_ok;
        zero0_d  = zero0_q;
        fwd_be_d = fwd_be_q;
        fwd_wd_d = fwd_wd_q;
        if (rd_ok) begin
            zero0_d  = !rd_in_range;
            fwd_wd_d = WD;
            fwd_be_d = ((FWD_EN != 0) && wr_ok && (WADDR == RADDR)) ? WBE : '0;
        end
    end

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            rd0[i*BYTE_W +: BYTE_W] = fwd_be_q[i] ? fwd_wd_q[i*BYTE_W +: BYTE_W]
                                                  : mem_rdata[i*BYTE_W +: BYTE_W];
        end
        if (zero0_q) begin
            rd0 = '0;
        end
        vld1_d = vld0_q;
        rd1_d  = vld0_q ? rd0 : rd1_q;
    end

    always_ff @(posedge CLK) begin
        if (SRST) begin
            state_q  <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            cnt_q    <= '0;
            vld0_q   <= 1'b0;
            zero0_q  <= 1'b1;
            fwd_be_q <= '0;
            vld1_q   <= 1'b0;
            rd1_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vld0_q   <= vld0_d;
            zero0_q  <= zero0_d;
            fwd_be_q <= fwd_be_d;
            fwd_wd_q <= fwd_wd_d;
            vld1_q   <= vld1_d;
            rd1_q    <= rd1_d;
        end
    end

    tpsram_core_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (CLK),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .wbe   (mem_wbe),
        .re    (mem_re),
        .raddr (RADDR),
        .rdata (mem_rdata)
    );

    assign RD       = (RD_PIPE != 0) ? rd1_q  : rd0;
    assign RD_VALID = (RD_PIPE != 0) ? vld1_q : vld0_q;
    assign BUSY     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_tpsram_pipe_ctrl.sv
// Scoreboard bench: u0 uses default parameters, u1 is 32-bit, 48 deep,
// pipelined, without forwarding. Expected read words are queued at issue time.
module tb_tpsram_pipe_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        srst0, wen0, ren0;
    logic [5:0]  waddr0, raddr0;
    logic [7:0]  wd0, rd0;
    logic [0:0]  wbe0;
    logic        rdv0, busy0;

    logic        srst1, wen1, ren1;
    logic [5:0]  waddr1, raddr1;
    logic [31:0] wd1, rd1;
    logic [3:0]  wbe1;
    logic        rdv1, busy1;

    int total = 0;
    int bad   = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int run0 = 0, last_run0 = 0;

    tpsram_pipe_ctrl u0 (
        .CLK(clk), .SRST(srst0), .WEN(wen0), .WADDR(waddr0), .WD(wd0), .WBE(wbe0),
        .REN(ren0), .RADDR(raddr0), .RD(rd0), .RD_VALID(rdv0), .BUSY(busy0)
    );

    tpsram_pipe_ctrl #(
        .DATA_WIDTH(32), .ADDR_WIDTH(6), .DEPTH(48), .RD_PIPE(1), .FWD_EN(0), .CLEAR_ON_RESET(1)
    ) u1 (
        .CLK(clk), .SRST(srst1), .WEN(wen1), .WADDR(waddr1), .WD(wd1), .WBE(wbe1),
        .REN(ren1), .RADDR(raddr1), .RD(rd1), .RD_VALID(rdv1), .BUSY(busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: pop one expected word per RD_VALID cycle.
    always @(negedge clk) begin
        if (rdv0 === 1'b1) begin
            if (q0.size() == 0) check("u0_unexpected_valid", 32'd1, 32'd0);
            else check("u0_rd", {24'd0, rd0}, q0.pop_front());
            run0 = run0 + 1;
        end else begin
            if (run0 != 0) last_run0 = run0;
            run0 = 0;
        end
        if (rdv1 === 1'b1) begin
            if (q1.size() == 0) check("u1_unexpected_valid", 32'd1, 32'd0);
            else check("u1_rd", rd1, q1.pop_front());
        end
    end

    task automatic wr0(input logic [5:0] a, input logic [7:0] d, input logic [0:0] be);
        wen0 = 1'b1; waddr0 = a; wd0 = d; wbe0 = be;
        @(posedge clk); #1;
        wen0 = 1'b0;
    endtask

    task automatic rd0_t(input logic [5:0] a, input logic [7:0] exp);
        q0.push_back({24'd0, exp});
        ren0 = 1'b1; raddr0 = a;
        @(posedge clk); #1;
        ren0 = 1'b0;
    endtask

    task automatic wr1(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        wen1 = 1'b1; waddr1 = a; wd1 = d; wbe1 = be;
        @(posedge clk); #1;
        wen1 = 1'b0;
    endtask

    task automatic rd1_t(input logic [5:0] a, input logic [31:0] exp);
        q1.push_back(exp);
        ren1 = 1'b1; raddr1 = a;
        @(posedge clk); #1;
        ren1 = 1'b0;
    endtask

    // Counts BUSY-high negedges starting right after a reset edge.
    task automatic count_busy(input int which, output int n);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (((which == 0) ? busy0 : busy1) !== 1'b1) break;
            n++;
        end
    endtask

    function automatic logic [7:0] pat0(input int a);
        return 8'((a * 7 + 3) ^ 8'h5A);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        srst0 = 1'b1; wen0 = 1'b0; ren0 = 1'b0; waddr0 = '0; raddr0 = '0; wd0 = '0; wbe0 = '0;
        srst1 = 1'b1; wen1 = 1'b0; ren1 = 1'b0; waddr1 = '0; raddr1 = '0; wd1 = '0; wbe1 = '0;
        repeat (2) @(posedge clk); #1;
        check("u0_rst_rd", {24'd0, rd0}, 32'd0);
        check("u0_rst_valid", {31'd0, rdv0}, 32'd0);
        check("u0_rst_busy", {31'd0, busy0}, 32'd1);
        check("u1_rst_rd", rd1, 32'd0);
        check("u1_rst_valid", {31'd0, rdv1}, 32'd0);

        // Sweep restarted at cycle 30 runs a full 64 cycles again.
        srst0 = 1'b0;
        repeat (30) @(posedge clk); #1;
        check("u0_mid_sweep_busy", {31'd0, busy0}, 32'd1);
        srst0 = 1'b1;
        @(posedge clk); #1;
        srst0 = 1'b0;
        count_busy(0, n);
        check("u0_busy_cycles", n, 32'd64);

        for (int a = 0; a < 64; a++) rd0_t(6'(a), 8'h00);
        repeat (3) @(posedge clk); #1;
        check("u0_clear_read_run", last_run0, 32'd64);

        wr0(6'd5, 8'hA5, 1'b1);
        rd0_t(6'd5, 8'hA5);
        check("u0_latency_valid", {31'd0, rdv0}, 32'd1);
        check("u0_latency_rd", {24'd0, rd0}, 32'h0000_00A5);

        for (int a = 0; a < 64; a++) wr0(6'(a), pat0(a), 1'b1);
        for (int a = 0; a < 64; a++) rd0_t(6'(a), pat0(a));
        repeat (3) @(posedge clk); #1;
        check("u0_b2b_run", last_run0, 32'd64);

        wr0(6'd9, 8'h0F, 1'b1);
        q0.push_back(32'h0000_00F0);
        wen0 = 1'b1; waddr0 = 6'd9; wd0 = 8'hF0; wbe0 = 1'b1;
        ren0 = 1'b1; raddr0 = 6'd9;
        @(posedge clk); #1;
        wen0 = 1'b0; ren0 = 1'b0;
        rd0_t(6'd9, 8'hF0);
        wr0(6'd9, 8'h55, 1'b0);
        rd0_t(6'd9, 8'hF0);
        repeat (4) @(posedge clk); #1;
        check("u0_hold_rd", {24'd0, rd0}, 32'h0000_00F0);
        check("u0_hold_valid", {31'd0, rdv0}, 32'd0);

        srst1 = 1'b0;
        count_busy(1, n);
        check("u1_busy_cycles", n, 32'd48);

        wr1(6'd3, 32'h1122_3344, 4'hF);
        wr1(6'd3, 32'hAABB_CCDD, 4'b0101);
        q1.push_back(32'h11BB_33DD);
        ren1 = 1'b1; raddr1 = 6'd3;
        @(posedge clk); #1;
        ren1 = 1'b0;
        check("u1_pipe_not_yet_valid", {31'd0, rdv1}, 32'd0);
        @(posedge clk); #1;
        check("u1_pipe_valid", {31'd0, rdv1}, 32'd1);
        check("u1_pipe_rd", rd1, 32'h11BB_33DD);

        wr1(6'd9, 32'h0000_000F, 4'hF);
        q1.push_back(32'h0000_000F);
        wen1 = 1'b1; waddr1 = 6'd9; wd1 = 32'h0000_00F0; wbe1 = 4'b0001;
        ren1 = 1'b1; raddr1 = 6'd9;
        @(posedge clk); #1;
        wen1 = 1'b0; ren1 = 1'b0;
        rd1_t(6'd9, 32'h0000_00F0);

        wr1(6'd50, 32'hDEAD_BEEF, 4'hF);
        rd1_t(6'd50, 32'h0000_0000);
        wr1(6'd47, 32'hCAFE_F00D, 4'hF);
        rd1_t(6'd47, 32'hCAFE_F00D);
        repeat (3) @(posedge clk); #1;

        // Reset one cycle after REN discards the in-flight read.
        ren1 = 1'b1; raddr1 = 6'd47;
        @(posedge clk); #1;
        ren1 = 1'b0; srst1 = 1'b1;
        @(posedge clk); #1;
        srst1 = 1'b0;
        check("u1_flush_valid", {31'd0, rdv1}, 32'd0);
        check("u1_flush_rd", rd1, 32'd0);
        count_busy(1, n);
        check("u1_busy_after_flush", n, 32'd48);
        rd1_t(6'd47, 32'h0000_0000);

        repeat (6) @(posedge clk); #1;
        check("u0_queue_drained", q0.size(), 32'd0);
        check("u1_queue_drained", q1.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
